uart_frame_receiver: RTL and testbench
======================================

# uart_frame_receiver

Receive-side counterpart of the capture-buffer UART streamer. Deserialises the 8N1 UART line, parses the streamer frame (`55 AA len_l len_h rate_sel trig_l trig_h` followed by payload), and writes the payload into a `sample_buffer`-style write port. It also latches the decoded header fields. Used for loopback verification and for loading replay patterns into on-chip RAM.

## Interface
- `ADDR_WIDTH`, 4, buffer address width; DEPTH = 1<<ADDR_WIDTH
- `CLK_FREQ`, 50_000_000, clock frequency in Hz
- `BAUD_RATE`, 115200, line rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division; 434 at the defaults)
- `GAP_TIMEOUT_BYTES`, 4, inter-byte timeout, expressed in byte times (10*BAUD_DIV clocks per byte time)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `uart_rx`  in  1  serial input; idles high; asynchronous to `clk`
- `wr_en`  out  1  one-cycle write strobe for one payload byte
- `wr_addr`  out  ADDR_WIDTH  write address; equals the payload byte index
- `wr_data`  out  8  payload byte
- `busy`  out  1  high while a frame is in progress (parser state not SYNC0)
- `frame_done`  out  1  one-cycle pulse when a frame completes without error
- `frame_err`  out  1  one-cycle pulse when a frame is aborted
- `err_cause`  out  2  abort cause, held until the next abort: 0 = bad length, 1 = trigger out of range, 2 = stop-bit error, 3 = timeout
- `frame_len`  out  16  LEN of the last good frame
- `rate_sel`  out  3  rate_sel[2:0] of the last good frame
- `trigger_index`  out  ADDR_WIDTH  trigger index of the last good frame

## Operation
- Input conditioning: `uart_rx` passes through a 2-flop synchroniser that resets to 1. All further logic uses the synchronised signal.
- Bit receiver states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - START: after BAUD_DIV/2 clocks, re-sample. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA: sample 8 bits, LSB first, one every BAUD_DIV clocks.
  - STOP: sample after a further BAUD_DIV clocks. If 1, pulse the internal `byte_valid` for one cycle. If 0, pulse `stop_err`. Either way, return to IDLE.
- Parser states: SYNC0, SYNC1, LEN_L, LEN_H, RATE, TRIG_L, TRIG_H, PAYLOAD.
  - SYNC0: 0x55 → SYNC1; any other byte stays in SYNC0.
  - SYNC1: 0xAA → LEN_L; 0x55 stays in SYNC1; any other byte → SYNC0.
  - LEN_L, LEN_H, RATE, TRIG_L, TRIG_H each capture their byte into shadow registers.
  - At the end of LEN_H: if len16 == 0 or len16 > DEPTH, abort with cause 0.
  - RATE: only bits [2:0] are kept; bits [7:3] are ignored.
  - At the end of TRIG_H: if trig16 >= len16, abort with cause 1. Otherwise clear the byte counter and enter PAYLOAD.
  - PAYLOAD: each byte issues a write with `wr_addr` = counter[ADDR_WIDTH-1:0] and `wr_data` = byte, then the counter increments. When counter reaches len16−1 (the last byte), pulse `frame_done` and copy the shadow registers into `frame_len`, `rate_sel` and `trigger_index`. Then return to SYNC0.
- Stop-bit error in any state other than SYNC0: abort with cause 2. In SYNC0 it is silently dropped.
- Timeout: a gap counter clears on every `byte_valid`. In any state other than SYNC0, reaching GAP_TIMEOUT_BYTES*10*BAUD_DIV clocks aborts with cause 3.
- Abort sequence: pulse `frame_err`, update `err_cause`, return to SYNC0. Payload bytes already written stay in RAM. Header output registers keep their previous values.

## Timing
- Reset values: `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `frame_done` = 0, `frame_err` = 0, `err_cause` = 0, `frame_len` = 0, `rate_sel` = 0, `trigger_index` = 0. Both FSMs go to IDLE/SYNC0.
- Reset mid-frame discards all progress. The first frame after reset is received normally.
- `byte_valid` is asserted 9.5 bit periods plus ≤3 clocks (synchroniser and edge detect) after the line's start edge.
- `wr_en`, `wr_addr` and `wr_data` are registered and valid in the cycle after `byte_valid`.
- `frame_done` and the header output update occur in the same cycle as the final `wr_en`.
- `frame_err` is asserted in the cycle after the triggering `byte_valid` / `stop_err`, or after timeout expiry.
- `busy` rises the cycle after 0x55 is accepted and falls in the same cycle as `frame_done` or `frame_err`.
- A new start bit can be accepted immediately after the stop-bit sample; back-to-back bytes with no idle time are supported.

## Test plan
- Frame `55 AA 10 00 00 06 00` followed by bytes 00..0F at 115200 baud → exactly 16 `wr_en`, with (addr, data) = (k, k); one `frame_done`; `frame_len` = 16, `trigger_index` = 6, `rate_sel` = 0; `frame_err` never asserts.
- Leading bytes `55 55 AA` with a valid header, length 4, rate byte 0xFD → accepted; `rate_sel` = 5; 4 writes.
- len = 17 (with ADDR_WIDTH = 4), and separately len = 0 → `frame_err` with `err_cause` = 0; zero writes; `busy` low afterwards.
- len = 16 with trig = 16 → `err_cause` = 1; then a valid frame → `frame_done`, and `trigger_index` reflects only the good frame.
- Stop bit forced to 0 on payload byte 3 → writes at addr 0..2, then `err_cause` = 2. Separately, a 1 µs low glitch on an idle line → no byte received.
- Stall for 5 byte times after the header → `err_cause` = 3. Separately, assert `rst_n` low mid-payload → all outputs at reset values; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_frame_receiver.sv
// 8N1 UART deserialiser plus streamer-frame parser: decodes the 55 AA header,
// writes the payload to a buffer write port and latches the header fields.
module uart_frame_receiver #(
  parameter int ADDR_WIDTH        = 4,
  parameter int CLK_FREQ          = 50_000_000,
  parameter int BAUD_RATE         = 115200,
  parameter int GAP_TIMEOUT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_rx,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic [1:0]            err_cause,
  output logic [15:0]           frame_len,
  output logic [2:0]            rate_sel,
  output logic [ADDR_WIDTH-1:0] trigger_index
);

  localparam int              BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int              CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0]   FULL_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam int              GAP_LIMIT = GAP_TIMEOUT_BYTES * 10 * BAUD_DIV;
  localparam int              GW        = $clog2(GAP_LIMIT + 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(GAP_LIMIT - 1);
  localparam logic [15:0]     DEPTH16   = 16'(1 << ADDR_WIDTH);

  localparam logic [1:0] CAUSE_LEN     = 2'd0;
  localparam logic [1:0] CAUSE_TRIG    = 2'd1;
  localparam logic [1:0] CAUSE_STOP    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    P_SYNC0, P_SYNC1, P_LEN_L, P_LEN_H, P_RATE, P_TRIG_L, P_TRIG_H, P_PAYLOAD
  } p_state_t;

  logic            rx_meta, rx_sync, rx_prev;
  logic            fall_edge;
  rx_state_t       rx_state, rx_next;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_q;
  logic            baud_hit, byte_valid, stop_err;

  p_state_t        p_state, p_next;
  logic [15:0]     len_q, trig_q, pay_cnt;
  logic [2:0]      rate_q;
  logic [GW-1:0]   gap_cnt;
  logic            timeout;
  logic            do_write, do_done, do_abort;
  logic [1:0]      abort_cause;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_edge = rx_prev & ~rx_sync;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    baud_hit   = (rx_state == RX_START) ? (baud_cnt == HALF_LAST) : (baud_cnt == FULL_LAST);
    case (rx_state)
      RX_IDLE:  if (fall_edge) rx_next = RX_START;
      RX_START: if (baud_hit) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (baud_hit && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (baud_hit) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_sync;
          stop_err   = ~rx_sync;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      rx_state <= rx_next;
      baud_cnt <= (rx_state == RX_IDLE || baud_hit) ? '0 : baud_cnt + 1'b1;
      if (rx_state != RX_DATA) bit_idx <= '0;
      else if (baud_hit)       bit_idx <= bit_idx + 1'b1;
      if (rx_state == RX_DATA && baud_hit) shift_q <= {rx_sync, shift_q[7:1]};
    end
  end

  assign timeout = (p_state != P_SYNC0) && (gap_cnt == GAP_LAST);

  // Stop errors outrank data; a timeout only fires on a cycle without a byte.
  always_comb begin
    p_next      = p_state;
    do_write    = 1'b0;
    do_done     = 1'b0;
    do_abort    = 1'b0;
    abort_cause = CAUSE_LEN;
    if (stop_err && p_state != P_SYNC0) begin
      do_abort    = 1'b1;
      abort_cause = CAUSE_STOP;
    end else if (byte_valid) begin
      case (p_state)
        P_SYNC0:  if (shift_q == 8'h55) p_next = P_SYNC1;
        P_SYNC1: begin
          if (shift_q == 8'hAA)      p_next = P_LEN_L;
          else if (shift_q != 8'h55) p_next = P_SYNC0;
        end
        P_LEN_L:  p_next = P_LEN_H;
        P_LEN_H: begin
          if ({shift_q, len_q[7:0]} == 16'd0 || {shift_q, len_q[7:0]} > DEPTH16) begin
            do_abort    = 1'b1;
            abort_cause = CAUSE_LEN;
          end else begin
            p_next = P_RATE;
          end
        end
        P_RATE:   p_next = P_TRIG_L;
        P_TRIG_L: p_next = P_TRIG_H;
        P_TRIG_H: begin
          if ({shift_q, trig_q[7:0]} >= len_q) begin
            do_abort    = 1'b1;
            abort_cause = CAUSE_TRIG;
          end else begin
            p_next = P_PAYLOAD;
          end
        end
        P_PAYLOAD: begin
          do_write = 1'b1;
          if (pay_cnt == len_q - 16'd1) begin
            do_done = 1'b1;
            p_next  = P_SYNC0;
          end
        end
        default:  p_next = P_SYNC0;
      endcase
    end else if (timeout) begin
      do_abort    = 1'b1;
      abort_cause = CAUSE_TIMEOUT;
    end
    if (do_abort) p_next = P_SYNC0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state       <= P_SYNC0;
      len_q         <= '0;
      trig_q        <= '0;
      rate_q        <= '0;
      pay_cnt       <= '0;
      gap_cnt       <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      err_cause     <= '0;
      frame_len     <= '0;
      rate_sel      <= '0;
      trigger_index <= '0;
    end else begin
      p_state <= p_next;
      if (byte_valid || p_state == P_SYNC0) gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST)         gap_cnt <= gap_cnt + 1'b1;
      if (byte_valid) begin
        case (p_state)
          P_LEN_L:  len_q[7:0]   <= shift_q;
          P_LEN_H:  len_q[15:8]  <= shift_q;
          P_RATE:   rate_q       <= shift_q[2:0];
          P_TRIG_L: trig_q[7:0]  <= shift_q;
          P_TRIG_H: begin
            trig_q[15:8] <= shift_q;
            pay_cnt      <= '0;
          end
          default: ;
        endcase
      end
      if (do_write) begin
        pay_cnt <= pay_cnt + 16'd1;
        wr_addr <= pay_cnt[ADDR_WIDTH-1:0];
        wr_data <= shift_q;
      end
      wr_en      <= do_write;
      frame_done <= do_done;
      frame_err  <= do_abort;
      if (do_abort) err_cause <= abort_cause;
      if (do_done) begin
        frame_len     <= len_q;
        rate_sel      <= rate_q;
        trigger_index <= trig_q[ADDR_WIDTH-1:0];
      end
    end
  end

  assign busy = (p_state != P_SYNC0);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Self-checking bench for uart_frame_receiver: serial frames are driven bit by
// bit and outcomes are predicted from the frame fields with plain arithmetic.
module tb_uart_frame_receiver;

  localparam int AW  = 4;
  localparam int CF  = 8_000_000;
  localparam int BR  = 1_000_000;
  localparam int GTB = 4;
  localparam int BIT = CF / BR;

  logic          clk, rst_n, uart_rx;
  logic          wr_en, busy, frame_done, frame_err;
  logic [AW-1:0] wr_addr, trigger_index;
  logic [7:0]    wr_data;
  logic [1:0]    err_cause;
  logic [15:0]   frame_len;
  logic [2:0]    rate_sel;

  uart_frame_receiver #(
    .ADDR_WIDTH(AW), .CLK_FREQ(CF), .BAUD_RATE(BR), .GAP_TIMEOUT_BYTES(GTB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .err_cause(err_cause), .frame_len(frame_len), .rate_sel(rate_sel),
    .trigger_index(trigger_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t        wr_q[$];
  int         done_cnt = 0, err_cnt = 0, done_with_wr = 0;
  logic [1:0] last_cause = 2'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) wr_q.push_back(wr_t'{wr_addr, wr_data});
      if (frame_done) begin
        done_cnt++;
        if (wr_en) done_with_wr++;
      end
      if (frame_err) begin
        err_cnt++;
        last_cause = err_cause;
      end
    end
  end

  int          n_cmp = 0, n_fail = 0;
  int          exp_len = 0, exp_rate = 0, exp_trig = 0, exp_cause = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(BIT);
    end
    uart_rx = stop_bit;
    idle(BIT);
    if (!stop_bit) begin
      uart_rx = 1'b1;
      idle(BIT);
    end
  endtask

  task automatic check_headers(input string tag);
    check({tag, ".frame_len"},     32'(frame_len),     32'(exp_len));
    check({tag, ".rate_sel"},      32'(rate_sel),      32'(exp_rate));
    check({tag, ".trigger_index"}, 32'(trigger_index), 32'(exp_trig));
    check({tag, ".err_cause"},     32'(err_cause),     32'(exp_cause));
  endtask

  // Outcome is derived from the header fields alone: a length outside 1..DEPTH
  // aborts, a trigger at or beyond the length aborts, a bad stop bit on payload
  // byte e leaves e writes, otherwise all len bytes land at addresses 0..len-1.
  task automatic run_frame(input string tag, input int n55, input int len,
                           input logic [7:0] rate_byte, input int trig,
                           input int bad_idx, input bit ramp, input bit glitch);
    logic [7:0] pay[$];
    int n_send, n_wr, exp_done, exp_err, new_cause;
    int base_wr, base_done, base_err, base_dw;
    if (len < 1 || len > (1 << AW)) begin
      n_send = 0; n_wr = 0; exp_done = 0; exp_err = 1; new_cause = 0;
    end else if (trig >= len) begin
      n_send = 0; n_wr = 0; exp_done = 0; exp_err = 1; new_cause = 1;
    end else if (bad_idx >= 0) begin
      n_send = bad_idx + 1; n_wr = bad_idx; exp_done = 0; exp_err = 1; new_cause = 2;
    end else begin
      n_send = len; n_wr = len; exp_done = 1; exp_err = 0; new_cause = exp_cause;
    end
    for (int k = 0; k < n_send; k++) pay.push_back(ramp ? 8'(k) : 8'($urandom));
    base_wr = wr_q.size(); base_done = done_cnt; base_err = err_cnt; base_dw = done_with_wr;

    for (int i = 0; i < n55; i++) send_byte(8'h55, 1'b1);
    if (glitch) begin
      uart_rx = 1'b0;
      idle(2);
      uart_rx = 1'b1;
      idle(2 * BIT);
    end
    send_byte(8'hAA, 1'b1);
    check({tag, ".busy_mid"}, 32'(busy), 32'd1);
    send_byte(8'(len), 1'b1);
    send_byte(8'(len >> 8), 1'b1);
    send_byte(rate_byte, 1'b1);
    send_byte(8'(trig), 1'b1);
    send_byte(8'(trig >> 8), 1'b1);
    for (int k = 0; k < n_send; k++) send_byte(pay[k], (k == bad_idx) ? 1'b0 : 1'b1);
    idle(3 * BIT);

    if (exp_done == 1) begin
      exp_len = len; exp_rate = int'(rate_byte[2:0]); exp_trig = trig;
    end
    exp_cause = new_cause;
    check({tag, ".n_writes"},   32'(wr_q.size() - base_wr),    32'(n_wr));
    for (int k = 0; k < n_wr && base_wr + k < wr_q.size(); k++) begin
      check({tag, ".wr_addr"}, 32'(wr_q[base_wr + k].addr), 32'(k));
      check({tag, ".wr_data"}, 32'(wr_q[base_wr + k].data), 32'(pay[k]));
    end
    check({tag, ".n_done"},     32'(done_cnt - base_done),     32'(exp_done));
    check({tag, ".done_at_wr"}, 32'(done_with_wr - base_dw),   32'(exp_done));
    check({tag, ".n_err"},      32'(err_cnt - base_err),       32'(exp_err));
    if (exp_err == 1) check({tag, ".err_cause_at_pulse"}, 32'(last_cause), 32'(new_cause));
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check_headers(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".wr_en"},      32'(wr_en),      32'd0);
    check({tag, ".wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, ".wr_data"},    32'(wr_data),    32'd0);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
    check({tag, ".frame_err"},  32'(frame_err),  32'd0);
    check_headers(tag);
  endtask

  initial begin
    int base_err, base_wr, len, trig;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    idle(5);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(2 * BIT);

    run_frame("ramp16",   1, 16, 8'h00, 6, -1, 1'b1, 1'b0);
    run_frame("sync55",   2,  4, 8'hFD, int'($urandom_range(0, 3)), -1, 1'b0, 1'b0);
    run_frame("len17",    1, 17, 8'($urandom), 0, -1, 1'b0, 1'b0);
    run_frame("len0",     1,  0, 8'($urandom), 0, -1, 1'b0, 1'b0);
    run_frame("trig16",   1, 16, 8'h03, 16, -1, 1'b0, 1'b0);
    len = int'($urandom_range(1, 16));
    run_frame("after_trig", 1, len, 8'($urandom), int'($urandom_range(0, len - 1)), -1, 1'b0, 1'b0);
    run_frame("stop_err", 1, 8, 8'h02, 1, 3, 1'b0, 1'b0);
    run_frame("glitch",   1, 5, 8'h07, 4, -1, 1'b0, 1'b1);

    // A bad stop bit while hunting for sync is dropped silently.
    base_err = err_cnt;
    send_byte(8'h3C, 1'b0);
    idle(2 * BIT);
    check("sync0_stop.n_err", 32'(err_cnt - base_err), 32'd0);
    check("sync0_stop.busy",  32'(busy), 32'd0);

    // Stall after a valid header: no abort at 3.5 byte times, abort by 5.
    base_err = err_cnt;
    base_wr  = wr_q.size();
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(35 * BIT);
    check("timeout.early_err", 32'(err_cnt - base_err), 32'd0);
    check("timeout.early_busy", 32'(busy), 32'd1);
    idle(15 * BIT);
    exp_cause = 3;
    check("timeout.n_err",    32'(err_cnt - base_err), 32'd1);
    check("timeout.n_writes", 32'(wr_q.size() - base_wr), 32'd0);
    check("timeout.busy",     32'(busy), 32'd0);
    check_headers("timeout");

    // Reset in the middle of a payload byte.
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
    uart_rx = 1'b0;
    idle(BIT + 3);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    idle(2);
    exp_len = 0; exp_rate = 0; exp_trig = 0; exp_cause = 0;
    check_reset_values("midreset");
    idle(BIT);
    rst_n = 1'b1;
    idle(2 * BIT);
    run_frame("post_reset", 1, 10, 8'h06, 9, -1, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      len  = int'($urandom_range(1, 16));
      trig = int'($urandom_range(0, len - 1));
      run_frame("random", 1, len, 8'($urandom), trig, -1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
